// File: rtl/pcie_prp_mrd_issue.sv
// PRP list read issue stage: splits a job into 1- or 2-beat memory reads, allocates one
// tracker tag per read, and signals done once all completion data has been retired.
module pcie_prp_mrd_issue #(
  parameter int unsigned C_PCIE_DATA_WIDTH  = 512,
  parameter int unsigned P_FIFO_DEPTH_WIDTH = 5,
  parameter logic [4:0]  C_TAG_PREFIX       = 5'b00001
) (
  input  logic                          pcie_user_clk,
  input  logic                          pcie_user_rst_n,
  input  logic                          prp_rd_req,
  input  logic [57:0]                   prp_rd_addr,
  input  logic [8:0]                    prp_rd_len,
  output logic                          prp_rd_ready,
  output logic                          prp_rd_done,
  output logic                          tx_mrd_req,
  input  logic                          tx_mrd_ack,
  output logic [63:0]                   tx_mrd_addr,
  output logic [9:0]                    tx_mrd_len,
  output logic [7:0]                    tx_mrd_tag,
  output logic                          pcie_tag_alloc,
  output logic [7:0]                    pcie_alloc_tag,
  output logic [1:0]                    pcie_tag_alloc_len,
  input  logic                          pcie_tag_full_n,
  input  logic [P_FIFO_DEPTH_WIDTH:0]   rear_full_addr,
  input  logic [P_FIFO_DEPTH_WIDTH:0]   rear_addr,
  input  logic [P_FIFO_DEPTH_WIDTH:0]   fifo_front_addr
);

  localparam int unsigned PtrW = P_FIFO_DEPTH_WIDTH + 1;
  localparam int unsigned SpcW = P_FIFO_DEPTH_WIDTH + 2;
  localparam logic [9:0] BeatDw = 10'(C_PCIE_DATA_WIDTH / 32);
  localparam logic [SpcW-1:0] FifoDepth = SpcW'(2 ** P_FIFO_DEPTH_WIDTH);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StReq,
    StNext,
    StWaitCpl,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [57:0]      addr_q, addr_d;
  logic [8:0]       len_q, len_d;
  logic [2:0]       tag_cnt_q, tag_cnt_d;
  logic [1:0]       chunk_q, chunk_d;
  logic [PtrW-1:0]  end_ptr_q, end_ptr_d;
  logic             req_q, req_d;
  logic [63:0]      mrd_addr_q, mrd_addr_d;
  logic [9:0]       mrd_len_q, mrd_len_d;
  logic [7:0]       mrd_tag_q, mrd_tag_d;

  logic [1:0]       chunk;
  logic [PtrW-1:0]  used;
  logic [SpcW-1:0]  need;
  logic             issue_ok;
  logic [8:0]       len_left;

  // Single beat at the last beat of a 4KB page so no read crosses the boundary.
  assign chunk    = (len_q == 9'd1 || addr_q[5:0] == 6'h3F) ? 2'd1 : 2'd2;
  assign used     = rear_full_addr - fifo_front_addr;
  assign need     = {1'b0, used} + SpcW'(chunk);
  assign issue_ok = pcie_tag_full_n && (need <= FifoDepth);
  assign len_left = len_q - 9'(chunk_q);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    tag_cnt_d  = tag_cnt_q;
    chunk_d    = chunk_q;
    end_ptr_d  = end_ptr_q;
    req_d      = req_q;
    mrd_addr_d = mrd_addr_q;
    mrd_len_d  = mrd_len_q;
    mrd_tag_d  = mrd_tag_q;
    case (state_q)
      StIdle: begin
        if (prp_rd_req) begin
          addr_d  = prp_rd_addr;
          len_d   = prp_rd_len;
          state_d = (prp_rd_len == 9'd0) ? StDone : StCheck;
        end
      end
      StCheck: begin
        if (issue_ok) begin
          chunk_d    = chunk;
          mrd_addr_d = {addr_q, 6'b0};
          mrd_len_d  = 10'(chunk) * BeatDw;
          mrd_tag_d  = {C_TAG_PREFIX, tag_cnt_q};
          req_d      = 1'b1;
          state_d    = StReq;
        end
      end
      StReq: begin
        if (tx_mrd_ack) begin
          req_d   = 1'b0;
          state_d = StNext;
        end
      end
      StNext: begin
        // Gives the tracker a cycle to advance rear_full_addr before it is used again.
        addr_d    = addr_q + 58'(chunk_q);
        len_d     = len_left;
        tag_cnt_d = tag_cnt_q + 3'd1;
        if (len_left == 9'd0) begin
          end_ptr_d = rear_full_addr;
          state_d   = StWaitCpl;
        end else begin
          state_d = StCheck;
        end
      end
      StWaitCpl: begin
        if (rear_addr == end_ptr_q) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
    if (!pcie_user_rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      len_q      <= '0;
      tag_cnt_q  <= '0;
      chunk_q    <= '0;
      end_ptr_q  <= '0;
      req_q      <= 1'b0;
      mrd_addr_q <= '0;
      mrd_len_q  <= '0;
      mrd_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      tag_cnt_q  <= tag_cnt_d;
      chunk_q    <= chunk_d;
      end_ptr_q  <= end_ptr_d;
      req_q      <= req_d;
      mrd_addr_q <= mrd_addr_d;
      mrd_len_q  <= mrd_len_d;
      mrd_tag_q  <= mrd_tag_d;
    end
  end

  assign prp_rd_ready       = (state_q == StIdle);
  assign prp_rd_done        = (state_q == StDone);
  assign tx_mrd_req         = req_q;
  assign tx_mrd_addr        = mrd_addr_q;
  assign tx_mrd_len         = mrd_len_q;
  assign tx_mrd_tag         = mrd_tag_q;
  assign pcie_tag_alloc     = (state_q == StReq) && tx_mrd_ack;
  assign pcie_alloc_tag     = mrd_tag_q;
  assign pcie_tag_alloc_len = chunk_q;

endmodule

// File: tb/tb_pcie_prp_mrd_issue.sv
// Bench for pcie_prp_mrd_issue: directed scenarios plus random jobs against a request-list model.
module tb_pcie_prp_mrd_issue;

  localparam int FW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          prp_rd_req = 1'b0;
  logic [57:0]   prp_rd_addr = '0;
  logic [8:0]    prp_rd_len = '0;
  logic          prp_rd_ready, prp_rd_done;
  logic          tx_mrd_req;
  logic          tx_mrd_ack = 1'b0;
  logic [63:0]   tx_mrd_addr;
  logic [9:0]    tx_mrd_len;
  logic [7:0]    tx_mrd_tag;
  logic          pcie_tag_alloc;
  logic [7:0]    pcie_alloc_tag;
  logic [1:0]    pcie_tag_alloc_len;
  logic          pcie_tag_full_n = 1'b1;
  logic [FW:0]   rf;
  logic [FW:0]   rear_addr = '0;
  logic [FW:0]   fifo_front_addr = '0;

  int            checks = 0;
  int            errors = 0;
  logic [2:0]    exp_tag = '0;
  int            alloc_tag_bad = 0;
  logic [63:0]   obs_addr[$];
  logic [9:0]    obs_len[$];
  logic [7:0]    obs_tag[$];
  logic [1:0]    obs_alen[$];

  pcie_prp_mrd_issue #(
    .C_PCIE_DATA_WIDTH (512),
    .P_FIFO_DEPTH_WIDTH(FW),
    .C_TAG_PREFIX      (5'b00001)
  ) dut (
    .pcie_user_clk     (clk),
    .pcie_user_rst_n   (rst_n),
    .prp_rd_req        (prp_rd_req),
    .prp_rd_addr       (prp_rd_addr),
    .prp_rd_len        (prp_rd_len),
    .prp_rd_ready      (prp_rd_ready),
    .prp_rd_done       (prp_rd_done),
    .tx_mrd_req        (tx_mrd_req),
    .tx_mrd_ack        (tx_mrd_ack),
    .tx_mrd_addr       (tx_mrd_addr),
    .tx_mrd_len        (tx_mrd_len),
    .tx_mrd_tag        (tx_mrd_tag),
    .pcie_tag_alloc    (pcie_tag_alloc),
    .pcie_alloc_tag    (pcie_alloc_tag),
    .pcie_tag_alloc_len(pcie_tag_alloc_len),
    .pcie_tag_full_n   (pcie_tag_full_n),
    .rear_full_addr    (rf),
    .rear_addr         (rear_addr),
    .fifo_front_addr   (fifo_front_addr)
  );

  always #5 clk = ~clk;

  // Tag tracker allocation pointer: advances by the allocated beat count.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rf <= '0;
    else if (pcie_tag_alloc) rf <= rf + (FW+1)'(pcie_tag_alloc_len);
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [57:0] a, input logic [8:0] l);
    prp_rd_addr = a;
    prp_rd_len  = l;
    prp_rd_req  = 1'b1;
    step();
    prp_rd_req  = 1'b0;
  endtask

  task automatic wait_req(input int lim, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < lim; c++) begin
      @(negedge clk);
      if (tx_mrd_req) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain(output bit to);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      fifo_front_addr = rear_addr;
      rear_addr = rf;
      @(negedge clk);
      if (prp_rd_done) begin
        got = 1'b1;
        break;
      end
      step();
    end
    step();
    to = !got;
  endtask

  // Runs one job with random ack latency and lagging completions, recording each allocation.
  task automatic run_job(input logic [57:0] a, input logic [8:0] l, input int ack_max,
                         input bit holdoff, output bit to);
    int dly, wcnt;
    bit got, nxt_ack;
    obs_addr.delete(); obs_len.delete(); obs_tag.delete(); obs_alen.delete();
    got = 1'b0;
    kick(a, l);
    dly = $urandom_range(ack_max, 0);
    wcnt = 0;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(negedge clk);
      if (pcie_tag_alloc) begin
        obs_addr.push_back(tx_mrd_addr);
        obs_len.push_back(tx_mrd_len);
        obs_tag.push_back(tx_mrd_tag);
        obs_alen.push_back(pcie_tag_alloc_len);
        if (pcie_alloc_tag !== tx_mrd_tag) alloc_tag_bad++;
      end
      if (prp_rd_done) got = 1'b1;
      nxt_ack = 1'b0;
      if (tx_mrd_ack) begin
        dly = $urandom_range(ack_max, 0);
        wcnt = 0;
      end else if (tx_mrd_req) begin
        if (wcnt >= dly) nxt_ack = 1'b1;
        else wcnt++;
      end
      step();
      tx_mrd_ack = nxt_ack;
      if (holdoff) pcie_tag_full_n = ($urandom_range(3, 0) != 0);
      if ($urandom_range(2, 0) != 0) begin
        fifo_front_addr = rear_addr;
        rear_addr = rf;
      end
    end
    tx_mrd_ack = 1'b0;
    pcie_tag_full_n = 1'b1;
    to = !got;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tx_mrd_ack = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (tx_mrd_req !== 1'b0) begin errors++;
      $display("FAIL rst_req got %b want 0", tx_mrd_req); end
    checks++; if (prp_rd_done !== 1'b0) begin errors++;
      $display("FAIL rst_done got %b want 0", prp_rd_done); end
    checks++; if (pcie_tag_alloc !== 1'b0) begin errors++;
      $display("FAIL rst_alloc got %b want 0", pcie_tag_alloc); end
    checks++; if (prp_rd_ready !== 1'b1) begin errors++;
      $display("FAIL rst_ready got %b want 1", prp_rd_ready); end
    checks++;
    if (tx_mrd_addr !== 64'h0 || tx_mrd_len !== 10'h0 || tx_mrd_tag !== 8'h0 ||
        pcie_alloc_tag !== 8'h0 || pcie_tag_alloc_len !== 2'h0) begin
      errors++;
      $display("FAIL rst_fields got %h/%h/%h/%h/%h want zeros", tx_mrd_addr, tx_mrd_len,
               tx_mrd_tag, pcie_alloc_tag, pcie_tag_alloc_len);
    end
    tx_mrd_ack = 1'b0;
    step();
    rst_n = 1'b1;
    exp_tag = '0;
  endtask

  task automatic test_split();
    logic [63:0] xa[3];
    logic [9:0]  xl[3];
    logic [1:0]  xc[3];
    bit to;
    xa = '{64'h1000, 64'h1080, 64'h1100};
    xl = '{10'd32, 10'd32, 10'd16};
    xc = '{2'd2, 2'd2, 2'd1};
    run_job(58'h40, 9'd5, 0, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL split_done got timeout want done"); end
    checks++; if (obs_addr.size() != 3) begin errors++;
      $display("FAIL split_count got %0d want 3", obs_addr.size()); end
    for (int i = 0; i < 3 && i < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== xa[i] || obs_len[i] !== xl[i] || obs_tag[i] !== 8'h08 + 8'(i) ||
          obs_alen[i] !== xc[i]) begin
        errors++;
        $display("FAIL split_req%0d got %h/%0d/%h/%0d want %h/%0d/%h/%0d", i, obs_addr[i],
                 obs_len[i], obs_tag[i], obs_alen[i], xa[i], xl[i], 8'h08 + 8'(i), xc[i]);
      end
    end
    exp_tag = exp_tag + 3'd3;
  endtask

  task automatic test_4k();
    bit to;
    run_job(58'h7F, 9'd3, 1, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL split4k_done got timeout want done"); end
    checks++;
    if (obs_addr.size() != 2) begin
      errors++;
      $display("FAIL split4k_count got %0d want 2", obs_addr.size());
    end else if (obs_addr[0] !== 64'h1FC0 || obs_len[0] !== 10'd16 || obs_tag[0] !== 8'h0B ||
                 obs_addr[1] !== 64'h2000 || obs_len[1] !== 10'd32 || obs_tag[1] !== 8'h0C) begin
      errors++;
      $display("FAIL split4k_reqs got %h/%0d/%h %h/%0d/%h want 1fc0/16/0b 2000/32/0c",
               obs_addr[0], obs_len[0], obs_tag[0], obs_addr[1], obs_len[1], obs_tag[1]);
    end
    exp_tag = exp_tag + 3'd2;
  endtask

  task automatic test_space();
    int cnt;
    bit seen, to;
    rear_addr = rf;
    fifo_front_addr = rf - 6'd31;
    kick(58'h4, 9'd2);
    cnt = 0;
    repeat (6) begin @(negedge clk); if (tx_mrd_req) cnt++; end
    checks++; if (cnt != 0) begin errors++;
      $display("FAIL space_block got %0d req cycles want 0", cnt); end
    step();
    fifo_front_addr = rf - 6'd30;
    wait_req(4, seen);
    checks++;
    if (!seen || tx_mrd_addr !== 64'h100 || tx_mrd_len !== 10'd32) begin
      errors++;
      $display("FAIL space_free got %b/%h/%0d want 1/100/32", seen, tx_mrd_addr, tx_mrd_len);
    end
    step(); tx_mrd_ack = 1'b1; step(); tx_mrd_ack = 1'b0;
    drain(to);
    checks++; if (to) begin errors++; $display("FAIL space_done got timeout want done"); end
    exp_tag++;
    rear_addr = rf;
    fifo_front_addr = rf - 6'd31;
    kick(58'h5, 9'd1);
    wait_req(4, seen);
    checks++; if (!seen || tx_mrd_len !== 10'd16) begin errors++;
      $display("FAIL space_edge got %b/%0d want 1/16", seen, tx_mrd_len); end
    step(); tx_mrd_ack = 1'b1; step(); tx_mrd_ack = 1'b0;
    drain(to);
    checks++; if (to) begin errors++; $display("FAIL space_edge_done got timeout want done"); end
    exp_tag++;
  endtask

  task automatic test_tag_full_ack();
    int cnt, acnt;
    bit seen, stable, to;
    logic [63:0] a;
    logic [9:0] l;
    logic [7:0] t;
    pcie_tag_full_n = 1'b0;
    tx_mrd_ack = 1'b1;
    kick(58'h20, 9'd2);
    cnt = 0; acnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (tx_mrd_req) cnt++;
      if (pcie_tag_alloc) acnt++;
    end
    checks++; if (cnt != 0 || acnt != 0) begin errors++;
      $display("FAIL tagfull_block got req %0d alloc %0d want 0 0", cnt, acnt); end
    step();
    tx_mrd_ack = 1'b0;
    pcie_tag_full_n = 1'b1;
    wait_req(5, seen);
    a = tx_mrd_addr; l = tx_mrd_len; t = tx_mrd_tag;
    checks++;
    if (!seen || a !== 64'h800 || l !== 10'd32 || t !== {5'b00001, exp_tag}) begin
      errors++;
      $display("FAIL tagfull_issue got %b/%h/%0d/%h want 1/800/32/%h", seen, a, l, t,
               {5'b00001, exp_tag});
    end
    stable = 1'b1; acnt = 0;
    repeat (4) begin
      step();
      @(negedge clk);
      if (!tx_mrd_req || tx_mrd_addr !== a || tx_mrd_len !== l || tx_mrd_tag !== t) stable = 0;
      if (pcie_tag_alloc) acnt++;
    end
    checks++; if (!stable || acnt != 0) begin errors++;
      $display("FAIL ackdly_hold got stable %b alloc %0d want 1 0", stable, acnt); end
    step();
    tx_mrd_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (pcie_tag_alloc !== 1'b1 || pcie_alloc_tag !== t || pcie_tag_alloc_len !== 2'd2) begin
      errors++;
      $display("FAIL ackdly_alloc got %b/%h/%0d want 1/%h/2", pcie_tag_alloc, pcie_alloc_tag,
               pcie_tag_alloc_len, t);
    end
    step();
    tx_mrd_ack = 1'b0;
    @(negedge clk);
    checks++; if (pcie_tag_alloc !== 1'b0 || tx_mrd_req !== 1'b0) begin errors++;
      $display("FAIL ackdly_after got %b/%b want 0/0", pcie_tag_alloc, tx_mrd_req); end
    step();
    drain(to);
    checks++; if (to) begin errors++; $display("FAIL ackdly_done got timeout want done"); end
    exp_tag++;
  endtask

  task automatic test_done();
    int dcnt;
    bit seen;
    logic [FW:0] base;
    rear_addr = rf;
    fifo_front_addr = rf;
    base = rf;
    kick(58'h0, 9'd1);
    wait_req(5, seen);
    checks++; if (!seen) begin errors++; $display("FAIL done_req got 0 want 1"); end
    step(); tx_mrd_ack = 1'b1; step(); tx_mrd_ack = 1'b0;
    dcnt = 0;
    repeat (6) begin @(negedge clk); if (prp_rd_done) dcnt++; end
    checks++; if (dcnt != 0) begin errors++;
      $display("FAIL done_early got %0d pulses want 0", dcnt); end
    checks++; if (rf !== base + 6'd1) begin errors++;
      $display("FAIL done_endptr got %0d want %0d", rf, base + 6'd1); end
    step();
    rear_addr = rf;
    fifo_front_addr = rf;
    @(negedge clk);
    checks++; if (prp_rd_done !== 1'b0) begin errors++;
      $display("FAIL done_same_cycle got %b want 0", prp_rd_done); end
    @(negedge clk);
    checks++; if (prp_rd_done !== 1'b1) begin errors++;
      $display("FAIL done_pulse got %b want 1", prp_rd_done); end
    @(negedge clk);
    checks++; if (prp_rd_done !== 1'b0 || prp_rd_ready !== 1'b1) begin errors++;
      $display("FAIL done_end got %b/%b want 0/1", prp_rd_done, prp_rd_ready); end
    step();
    exp_tag++;
  endtask

  task automatic test_zero_len();
    int rcnt;
    kick(58'h123, 9'd0);
    rcnt = 0;
    @(negedge clk);
    if (tx_mrd_req) rcnt++;
    checks++; if (prp_rd_done !== 1'b1 || prp_rd_ready !== 1'b0) begin errors++;
      $display("FAIL zero_done got %b/%b want 1/0", prp_rd_done, prp_rd_ready); end
    @(negedge clk);
    if (tx_mrd_req) rcnt++;
    checks++; if (prp_rd_done !== 1'b0 || prp_rd_ready !== 1'b1 || rcnt != 0) begin errors++;
      $display("FAIL zero_after got %b/%b/%0d want 0/1/0", prp_rd_done, prp_rd_ready, rcnt); end
    step();
  endtask

  task automatic test_tag_wrap();
    bit to;
    int wraps;
    logic [7:0] prev;
    wraps = 0;
    prev = 8'h00;
    for (int i = 0; i < 9; i++) begin
      run_job(58'h0, 9'd2, 2, 1'b0, to);
      checks++;
      if (to || obs_tag.size() != 1) begin
        errors++;
        $display("FAIL wrap_job%0d got to %b n %0d want 0 1", i, to, obs_tag.size());
      end else begin
        if (obs_tag[0] !== {5'b00001, exp_tag}) begin
          errors++;
          $display("FAIL wrap_tag%0d got %h want %h", i, obs_tag[0], {5'b00001, exp_tag});
        end
        if (i > 0 && prev == 8'h0F && obs_tag[0] == 8'h08) wraps++;
        prev = obs_tag[0];
      end
      exp_tag++;
    end
    checks++; if (wraps != 1) begin errors++;
      $display("FAIL wrap_seen got %0d want 1", wraps); end
  endtask

  task automatic test_random();
    logic [57:0] a, ea;
    logic [8:0]  l, el;
    logic [1:0]  ch;
    bit hold, to;
    int k;
    for (int j = 0; j < 20; j++) begin
      a = 58'({$urandom(), $urandom()});
      if ($urandom_range(1, 0) == 1) a[5:0] = 6'h3F - 6'($urandom_range(2, 0));
      l = 9'($urandom_range(12, 0));
      if (j % 5 == 4) l = 9'($urandom_range(40, 13));
      hold = ($urandom_range(1, 0) == 1);
      run_job(a, l, 3, hold, to);
      checks++; if (to) begin errors++;
        $display("FAIL rnd_done job %0d got timeout want done", j); end
      ea = a; el = l; k = 0;
      while (el != 9'd0) begin
        ch = (el == 9'd1 || ea[5:0] == 6'h3F) ? 2'd1 : 2'd2;
        checks++;
        if (k >= obs_addr.size()) begin
          errors++;
          $display("FAIL rnd_missing job %0d req %0d got none want %h", j, k, {ea, 6'b0});
        end else if (obs_addr[k] !== {ea, 6'b0} || obs_len[k] !== 10'(ch) * 10'd16 ||
                     obs_tag[k] !== {5'b00001, exp_tag} || obs_alen[k] !== ch) begin
          errors++;
          $display("FAIL rnd_req job %0d req %0d got %h/%0d/%h/%0d want %h/%0d/%h/%0d", j, k,
                   obs_addr[k], obs_len[k], obs_tag[k], obs_alen[k], {ea, 6'b0},
                   10'(ch) * 10'd16, {5'b00001, exp_tag}, ch);
        end
        ea = ea + 58'(ch);
        el = el - 9'(ch);
        exp_tag++;
        k++;
      end
      checks++; if (obs_addr.size() != k) begin errors++;
        $display("FAIL rnd_count job %0d got %0d want %0d", j, obs_addr.size(), k); end
    end
    checks++; if (alloc_tag_bad != 0) begin errors++;
      $display("FAIL alloc_tag got %0d mismatches want 0", alloc_tag_bad); end
  endtask

  task automatic test_reset_mid();
    bit seen, to;
    kick(58'h0, 9'd4);
    wait_req(5, seen);
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_req got 0 want 1"); end
    #2;
    tx_mrd_ack = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx_mrd_req !== 1'b0 || prp_rd_ready !== 1'b1 || pcie_tag_alloc !== 1'b0 ||
        tx_mrd_addr !== 64'h0 || tx_mrd_tag !== 8'h0) begin
      errors++;
      $display("FAIL rstmid_async got %b/%b/%b/%h/%h want 0/1/0/0/0", tx_mrd_req, prp_rd_ready,
               pcie_tag_alloc, tx_mrd_addr, tx_mrd_tag);
    end
    tx_mrd_ack = 1'b0;
    step();
    rst_n = 1'b1;
    rear_addr = '0;
    fifo_front_addr = '0;
    exp_tag = '0;
    run_job(58'h0, 9'd1, 1, 1'b0, to);
    checks++;
    if (to || obs_tag.size() != 1 || obs_tag[0] !== 8'h08) begin
      errors++;
      $display("FAIL rstmid_tag got to %b n %0d want 0 1 tag 08", to, obs_tag.size());
    end
  endtask

  initial begin
    test_reset();
    test_split();
    test_4k();
    test_space();
    test_tag_full_ack();
    test_done();
    test_zero_len();
    test_tag_wrap();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
